// File: rtl/change_dispenser.sv
// change_dispenser: paces change payout through the 5-unit and 1-unit coin
// ejectors, greedy (5s first), one coin at a time: a PULSE_CYCLES drive pulse
// followed by a GAP_CYCLES mechanical recovery gap.
// Optional feature macro: CHANGE_TIMEOUT_EN adds a coin_sense handshake after
// each pulse with a TIMEOUT_CYCLES watchdog and a sticky FAULT state.
module change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int AMT_W          = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [AMT_W-1:0] amt,
  input  logic             coin_sense,
  output logic             busy,
  output logic             done,
  output logic             eject_hi,
  output logic             eject_lo,
  output logic [AMT_W-1:0] remaining,
  output logic             fault
);

  localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0]    P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]    G_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [AMT_W-1:0] FIVE   = AMT_W'(5);
  localparam logic [AMT_W-1:0] ONE    = AMT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
    S_GAP   = 3'd2,
`ifdef CHANGE_TIMEOUT_EN
    S_WAIT  = 3'd4,
    S_FAULT = 3'd5,
`endif
    S_DONE  = 3'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;      // cycles spent in PULSE / GAP
  logic          coin_hi;  // denomination of the coin in flight

  // Value removed from remaining when the current coin completes.
  logic [AMT_W-1:0] step;
  assign step = coin_hi ? FIVE : ONE;

`ifdef CHANGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tcnt;     // cycles spent waiting for coin_sense
`else
  // No handshake: sensor input and timeout are not used, fault never rises.
  logic unused_sense;
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign unused_sense = coin_sense;
  assign fault        = 1'b0;
`endif

  // Payout sequencer; all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      coin_hi   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      eject_hi  <= 1'b0;
      eject_lo  <= 1'b0;
      remaining <= '0;
`ifdef CHANGE_TIMEOUT_EN
      tcnt      <= '0;
      fault     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (amt != '0) begin
              // Greedy denomination is fixed as the pulse starts.
              remaining <= amt;
              coin_hi   <= (amt >= FIVE);
              eject_hi  <= (amt >= FIVE);
              eject_lo  <= (amt <  FIVE);
              cnt       <= '0;
              state     <= S_PULSE;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_PULSE: begin
          if (cnt == P_LAST) begin
            eject_hi <= 1'b0;
            eject_lo <= 1'b0;
            cnt      <= '0;
`ifdef CHANGE_TIMEOUT_EN
            tcnt     <= '0;
            state    <= S_WAIT;
`else
            remaining <= remaining - step;
            state     <= S_GAP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef CHANGE_TIMEOUT_EN
        S_WAIT: begin
          if (coin_sense) begin
            remaining <= remaining - step;
            state     <= S_GAP;
          end else if (tcnt == T_LAST) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        // Parked until reset; remaining is held for diagnosis.
        S_FAULT: state <= S_FAULT;
`endif
        S_GAP: begin
          if (cnt == G_LAST) begin
            cnt <= '0;
            if (remaining != '0) begin
              coin_hi  <= (remaining >= FIVE);
              eject_hi <= (remaining >= FIVE);
              eject_lo <= (remaining <  FIVE);
              state    <= S_PULSE;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser (default build, no timeout handshake).
// Reference model: for a request presented during the cycle opened by edge k,
// the expected outputs of any later cycle are computed directly from the coin
// schedule (floor(A/5) hi coins then A mod 5 lo coins, PULSE+GAP cycles each,
// done one cycle after the last coin).
module tb_change_dispenser;
  localparam int P = 4;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset, req, coin_sense;
  logic [3:0] amt;
  logic       busy, done, eject_hi, eject_lo, fault;
  logic [3:0] remaining;

  change_dispenser #(
    .PULSE_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT_CYCLES(64), .AMT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .amt(amt), .coin_sense(coin_sense),
    .busy(busy), .done(done), .eject_hi(eject_hi), .eject_lo(eject_lo),
    .remaining(remaining), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int edge_n = 0;

  // Model state: active payout, its start edge k, amount and coin count.
  bit m_act = 1'b0;
  int m_k = 0;
  int m_a = 0;
  int m_n = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, edge_n, act, exp);
  endtask

  // Called just after each rising edge with the inputs the DUT just sampled.
  task automatic model_edge();
    if (reset) begin
      m_act = 1'b0;
      return;
    end
    // The request is taken only if the cycle ending at this edge was IDLE.
    if (req && (!m_act || (edge_n - 1 - m_k) >= m_n * (P + G) + 2)) begin
      m_act = 1'b1;
      m_k   = edge_n - 1;
      m_a   = int'(amt);
      m_n   = m_a / 5 + m_a % 5;
    end
  endtask

  task automatic check_outputs();
    int t, d, i, ph, h, v, paid;
    int eb, ed, eh, el, er;
    eb = 0; ed = 0; eh = 0; el = 0; er = 0;
    if (m_act) begin
      t = edge_n - m_k;
      d = m_n * (P + G);
      if (t >= 1 && t <= d) begin
        eb   = 1;
        i    = (t - 1) / (P + G);
        ph   = (t - 1) % (P + G);
        h    = m_a / 5;
        v    = (i < h) ? 5 : 1;
        paid = (i < h) ? 5 * i : 5 * h + (i - h);
        er   = m_a - paid - ((ph >= P) ? v : 0);
        if (ph < P) begin
          if (i < h) eh = 1;
          else       el = 1;
        end
      end else if (t == d + 1) begin
        eb = 1;
        ed = 1;
      end
    end
    chk("busy",      int'(busy),      eb);
    chk("done",      int'(done),      ed);
    chk("eject_hi",  int'(eject_hi),  eh);
    chk("eject_lo",  int'(eject_lo),  el);
    chk("remaining", int'(remaining), er);
    chk("fault",     int'(fault),     0);
  endtask

  // One clock: drive at the falling edge, step the model at the rising
  // edge, check at the next falling edge.
  task automatic cyc(input bit r, input int a);
    req = r;
    amt = 4'(a);
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; amt = '0; coin_sense = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // amt=7: hi, lo, lo; done 25 edges after the request cycle opens.
    cyc(1'b1, 7);
    repeat (30) cyc(1'b0, 0);

    // amt=0: done and busy for exactly one cycle.
    cyc(1'b1, 0);
    repeat (4) cyc(1'b0, 0);

    // amt=10 with a second request mid-payout that must be dropped.
    cyc(1'b1, 10);
    repeat (5) cyc(1'b0, 0);
    cyc(1'b1, 3);
    repeat (25) cyc(1'b0, 0);

    // amt=15: three hi coins only.
    cyc(1'b1, 15);
    repeat (30) cyc(1'b0, 0);

    // Asynchronous reset in the middle of a hi pulse.
    cyc(1'b1, 7);
    cyc(1'b0, 0);
    cyc(1'b0, 0);
    @(posedge clk);
    edge_n++;
    model_edge();
    #2;
    chk("eject_hi_pre_reset", int'(eject_hi), 1);
    reset = 1'b1;
    m_act = 1'b0;
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    cyc(1'b0, 0);
    cyc(1'b1, 1);
    repeat (12) cyc(1'b0, 0);

    // Random requests, including back-to-back and ignored ones.
    repeat (3000) cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)));
    repeat (130) cyc(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
